key_conditioner: RTL

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 132 +++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// key_conditioner
//   Debounces an active-low, possibly bouncing push-button and produces a
//   clean level plus single-cycle press/release strobes and a press counter.
//
//   Parameters
//     DEBOUNCE_CYCLES  stable samples required after the first qualifying one
//     CNT_W            width of the debounce counter
//
//   Ports
//     clk            system clock, rising-edge
//     reset          synchronous, active-high
//     key_n          raw asynchronous button, 0 = pressed
//     pressed        debounced level, 1 while held
//     press_pulse    one-cycle strobe per debounced press
//     release_pulse  one-cycle strobe per debounced release
//     press_count    debounced presses since reset, wraps 255 -> 0
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             key_sync_p0;
  logic             key_sync_p1;
  logic             raw;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             press_set;
  logic             release_set;

  // Stage p0/p1: two-flop synchronizer. Reset value 1 means "not pressed",
  // so a button held through reset is seen as a fresh press afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_sync_p0 <= 1'b1;
      key_sync_p1 <= 1'b1;
    end else begin
      key_sync_p0 <= key_n;
      key_sync_p1 <= key_sync_p0;
    end
  end

  assign raw = ~key_sync_p1;

  // Debounce FSM next-state logic. cnt only moves in the two WAIT states and
  // is cleared on entry to them, so it never passes CNT_LAST.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    press_set   = 1'b0;
    release_set = 1'b0;
    case (state)
      IDLE: begin
        if (raw) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!raw) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = HELD;
          press_set  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!raw) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (raw) begin
          state_next = HELD;
        end else if (cnt == CNT_LAST) begin
          state_next  = IDLE;
          release_set = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs. Outputs are derived from the next state so
  // that pressed and the strobes appear on the same edge as the transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      pressed       <= (state_next == HELD) || (state_next == RELEASE_WAIT);
      press_pulse   <= press_set;
      release_pulse <= release_set;
      if (press_set) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

endmodule
